// File: rtl/decode_sequencer_if.sv
// decode_sequencer_if: frame output handshake between the sequencer and the frame consumer
interface decode_sequencer_if;
  logic frame_valid;
  logic frame_ready;
  logic [95:0] frame_data;
  modport master(output frame_valid, frame_data, input frame_ready);
  modport slave(input frame_valid, frame_data, output frame_ready);
endinterface

// File: rtl/decode_sequencer.sv
// decode_sequencer: frame capture, inter-bit timeout and decoder re-arm control; DECODE_SEQ_STATS_EN builds the timeout/overrun counters
module decode_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic serial_clock,
  input  logic decoder_full,
  input  logic [3:0] decoder_validations,
  input  logic [95:0] frame_in,
  output logic decoder_rearm,
  output logic busy,
  output logic [1:0] seq_state,
  output logic [7:0] timeout_count,
  output logic [7:0] overrun_count,
  decode_sequencer_if.master frame
);
  typedef enum logic [1:0] {IDLE = 2'd0, RECEIVING = 2'd1, REARM = 2'd2} state_t;
  localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);
  state_t state, state_next;
  logic [15:0] gap;
  logic [7:0] hold;
  logic receiving, free, capture, timeout_hit;
  assign receiving = state == RECEIVING;
  assign free = !frame.frame_valid || frame.frame_ready;
  assign capture = receiving && decoder_full && free;
  assign timeout_hit = receiving && !decoder_full && !serial_clock && gap == GAP_LAST;
  assign seq_state = state;
  assign busy = state != IDLE;
  assign decoder_rearm = state == REARM;
  // state register plus gap and holdoff timers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      gap <= '0;
      hold <= '0;
    end else begin
      state <= state_next;
      gap <= (!receiving || serial_clock) ? 16'd0 : gap + 16'd1;
      hold <= (state == REARM && state_next == REARM) ? hold + 8'd1 : 8'd0;
    end
  end
  // next-state: full frame beats timeout, re-arm lasts HOLDOFF_CYCLES
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = serial_clock ? RECEIVING : IDLE;
      RECEIVING: state_next = (decoder_full || timeout_hit) ? REARM : RECEIVING;
      REARM: state_next = hold == HOLD_LAST ? IDLE : REARM;
      default: state_next = IDLE;
    endcase
  end
  // one-deep output buffer; data only changes when the buffer is free
  always_ff @(posedge clock) begin
    if (reset) begin
      frame.frame_valid <= 1'b0;
      frame.frame_data <= '0;
    end else if (capture) begin
      frame.frame_valid <= 1'b1;
      frame.frame_data <= frame_in;
    end else if (frame.frame_valid && frame.frame_ready) begin
      frame.frame_valid <= 1'b0;
    end
  end
`ifdef DECODE_SEQ_STATS_EN
  logic locked, overrun_hit;
  assign overrun_hit = receiving && decoder_full && !free;
  // lock tracking and saturating event counters
  always_ff @(posedge clock) begin
    if (reset) begin
      locked <= 1'b0;
      timeout_count <= '0;
      overrun_count <= '0;
    end else begin
      locked <= (state == IDLE) ? 1'b0 : (locked || (receiving && &decoder_validations));
      if (timeout_hit && locked && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
      if (overrun_hit && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
    end
  end
`else
  logic unused_validations;
  assign unused_validations = &decoder_validations;
  assign timeout_count = '0;
  assign overrun_count = '0;
`endif
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed vectors and corner-case sequences for decode_sequencer (TIMEOUT 8, HOLDOFF 16)
module tb_decode_sequencer;
  logic clock = 1'b0;
  logic reset, serial_clock, decoder_full;
  logic [3:0] decoder_validations;
  logic [95:0] frame_in;
  logic decoder_rearm, busy;
  logic [1:0] seq_state;
  logic [7:0] timeout_count, overrun_count;
  int checks = 0;
  int passed = 0;
  localparam logic [95:0] PAT_A = 96'hA5A5A5A5A5A5A5A5A5A5A5A5;
  localparam logic [95:0] PAT_B = 96'h5A5A5A5A5A5A5A5A5A5A5A5A;
  localparam logic [95:0] D1 = 96'h111111112222222233333333;
  localparam logic [95:0] D2 = 96'h444444445555555566666666;
  localparam logic [95:0] D3 = 96'h777777778888888899999999;
  localparam logic [95:0] D4 = 96'hAAAAAAAABBBBBBBBCCCCCCCC;
  localparam logic [95:0] D5 = 96'hDEADBEEF0123456789ABCDEF;
  localparam logic [95:0] D6 = 96'hFEDCBA9876543210CAFEF00D;
  decode_sequencer_if fif();
  decode_sequencer #(.TIMEOUT_CYCLES(8), .HOLDOFF_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .serial_clock(serial_clock), .decoder_full(decoder_full),
    .decoder_validations(decoder_validations), .frame_in(frame_in), .decoder_rearm(decoder_rearm),
    .busy(busy), .seq_state(seq_state), .timeout_count(timeout_count), .overrun_count(overrun_count),
    .frame(fif)
  );
  always #5 clock = ~clock;
  typedef struct {
    bit sc;
    bit full;
    logic [95:0] din;
    bit exp_valid;
    bit exp_rearm;
    logic [1:0] exp_state;
    logic [95:0] exp_data;
  } vec_t;
  vec_t vecs[5];
  function automatic logic [7:0] ecnt(int n);
`ifdef DECODE_SEQ_STATS_EN
    return n > 255 ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && seq_state != 2'd0; i++) tick();
    chk("wait_idle", seq_state, 2'd0);
  endtask
  task automatic capture_frame(input logic [95:0] d, input logic r);
    serial_clock = 1'b1;
    decoder_validations = 4'hF;
    tick();
    serial_clock = 1'b0;
    tick();
    decoder_full = 1'b1;
    frame_in = d;
    fif.frame_ready = r;
    tick();
    decoder_full = 1'b0;
  endtask
  task automatic start_and_idle(input logic [3:0] v, input int n);
    decoder_validations = v;
    serial_clock = 1'b1;
    tick();
    serial_clock = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int rearm_cycles;
    reset = 1'b1; serial_clock = 1'b0; decoder_full = 1'b0;
    decoder_validations = 4'h0; frame_in = '0; fif.frame_ready = 1'b0;
    repeat (2) tick();
    chk("reset_valid", fif.frame_valid, 0);
    chk("reset_data", fif.frame_data, 0);
    chk("reset_rearm", decoder_rearm, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", seq_state, 0);
    chk("reset_tcount", timeout_count, 0);
    chk("reset_ocount", overrun_count, 0);
    reset = 1'b0;
    vecs[0] = '{1'b0, 1'b1, PAT_A, 1'b0, 1'b0, 2'd0, 96'h0};
    vecs[1] = '{1'b1, 1'b0, PAT_B, 1'b0, 1'b0, 2'd1, 96'h0};
    vecs[2] = '{1'b1, 1'b0, PAT_B, 1'b0, 1'b0, 2'd1, 96'h0};
    vecs[3] = '{1'b0, 1'b1, PAT_A, 1'b1, 1'b1, 2'd2, PAT_A};
    vecs[4] = '{1'b0, 1'b0, PAT_B, 1'b0, 1'b1, 2'd2, PAT_A};
    fif.frame_ready = 1'b1;
    decoder_validations = 4'hF;
    for (int i = 0; i < 5; i++) begin
      serial_clock = vecs[i].sc;
      decoder_full = vecs[i].full;
      frame_in = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_valid", i), fif.frame_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_rearm", i), decoder_rearm, vecs[i].exp_rearm);
      chk($sformatf("vec%0d_state", i), seq_state, vecs[i].exp_state);
      chk($sformatf("vec%0d_data", i), fif.frame_data, vecs[i].exp_data);
    end
    rearm_cycles = 2;
    serial_clock = 1'b1; decoder_full = 1'b1; frame_in = PAT_B;
    repeat (14) begin
      tick();
      rearm_cycles += int'(decoder_rearm);
    end
    tick();
    chk("rearm_len", rearm_cycles, 16);
    chk("rearm_end_state", seq_state, 0);
    chk("rearm_end_rearm", decoder_rearm, 0);
    chk("rearm_ignores_full", fif.frame_valid, 0);
    chk("rearm_ignores_ocount", overrun_count, 0);
    serial_clock = 1'b0; decoder_full = 1'b0;
    tick();
    chk("idle_after_rearm", seq_state, 0);
    fif.frame_ready = 1'b0;
    capture_frame(D1, 1'b0);
    chk("bp_first_valid", fif.frame_valid, 1);
    chk("bp_first_data", fif.frame_data, D1);
    wait_idle();
    chk("bp_hold_data", fif.frame_data, D1);
    capture_frame(D2, 1'b0);
    chk("bp_drop_state", seq_state, 2);
    chk("bp_drop_data", fif.frame_data, D1);
    chk("bp_drop_valid", fif.frame_valid, 1);
    chk("bp_ocount", overrun_count, ecnt(1));
    wait_idle();
    fif.frame_ready = 1'b1;
    tick();
    chk("bp_deliver_valid", fif.frame_valid, 0);
    chk("bp_deliver_data", fif.frame_data, D1);
    tick();
    chk("bp_only_one", fif.frame_valid, 0);
    fif.frame_ready = 1'b0;
    capture_frame(D3, 1'b0);
    wait_idle();
    chk("sim_pre_valid", fif.frame_valid, 1);
    capture_frame(D4, 1'b1);
    chk("sim_valid", fif.frame_valid, 1);
    chk("sim_data", fif.frame_data, D4);
    chk("sim_ocount", overrun_count, ecnt(1));
    tick();
    chk("sim_drain", fif.frame_valid, 0);
    wait_idle();
    start_and_idle(4'hF, 7);
    chk("tofull_pre_state", seq_state, 1);
    decoder_full = 1'b1; frame_in = D5;
    tick();
    decoder_full = 1'b0;
    chk("tofull_state", seq_state, 2);
    chk("tofull_valid", fif.frame_valid, 1);
    chk("tofull_data", fif.frame_data, D5);
    chk("tofull_tcount", timeout_count, ecnt(0));
    wait_idle();
    start_and_idle(4'hF, 7);
    chk("to_s7_state", seq_state, 1);
    chk("to_s7_rearm", decoder_rearm, 0);
    tick();
    chk("to_s8_state", seq_state, 2);
    chk("to_s8_rearm", decoder_rearm, 1);
    chk("to_tcount", timeout_count, ecnt(1));
    wait_idle();
    start_and_idle(4'h7, 8);
    chk("unlocked_rearm", decoder_rearm, 1);
    chk("unlocked_tcount", timeout_count, ecnt(1));
    wait_idle();
    start_and_idle(4'hF, 6);
    serial_clock = 1'b1;
    tick();
    serial_clock = 1'b0;
    tick();
    chk("late_strobe_state", seq_state, 1);
    repeat (6) tick();
    chk("late_strobe_s14", seq_state, 1);
    tick();
    chk("late_strobe_timeout", seq_state, 2);
    chk("late_strobe_tcount", timeout_count, ecnt(2));
    wait_idle();
    fif.frame_ready = 1'b0;
    capture_frame(D6, 1'b0);
    repeat (3) tick();
    chk("rst_pre_valid", fif.frame_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_valid", fif.frame_valid, 0);
    chk("rst_rearm", decoder_rearm, 0);
    chk("rst_state", seq_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tcount", timeout_count, 0);
    chk("rst_ocount", overrun_count, 0);
    tick();
    chk("rst_no_rearm", decoder_rearm, 0);
    for (int i = 1; i <= 300; i++) begin
      start_and_idle(4'hF, 8);
      repeat (16) tick();
      if (i == 100) chk("sat_100", timeout_count, ecnt(100));
      if (i == 255) chk("sat_255", timeout_count, ecnt(255));
    end
    chk("sat_300", timeout_count, ecnt(300));
    chk("sat_ocount", overrun_count, ecnt(0));
    chk("sat_state", seq_state, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
